sitcp_tcp_tx_framer: RTL and testbench

- Packs a stream of 32-bit samples into fixed-length frames and writes them bytewise into the SiTCP TCP TX FIFO interface (TCP_TX_WR / TCP_TX_DATA, backpressured by TCP_TX_FULL).
- Sits directly upstream of the SiTCP wrapper in the sys_clk domain.
- Emits frames only while a TCP connection is open (TCP_OPEN_ACK). Each frame carries a magic word and a sequence number so the host can detect loss and resynchronise.

---
 rtl/sitcp_tcp_tx_framer.sv | 202 ++++++++++++++++++++
 tb/tb_sitcp_tcp_tx_framer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sitcp_tcp_tx_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sitcp_tcp_tx_framer
// Brief    : Packs 32-bit samples into [MAGIC|seq|payload] frames and writes
//            them big-endian, one byte per cycle, into the SiTCP TCP TX FIFO.
//            Optional XOR trailer byte: define SITCP_TX_FRAMER_CHECKSUM_EN.
// Revision : 1.0  initial release
// ============================================================================
module sitcp_tcp_tx_framer #(
    parameter int unsigned SAMPLES_PER_FRAME = 64,
    parameter logic [31:0] MAGIC             = 32'hA5A5_5A5A
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic        TCP_OPEN_ACK,
    input  logic        TCP_TX_FULL,
    output logic        TCP_TX_WR,
    output logic [7:0]  TCP_TX_DATA,
    input  logic [31:0] S_DATA,
    input  logic        S_VALID,
    output logic        S_READY,
    output logic [31:0] FRAME_CNT,
    output logic [15:0] ABORT_CNT
);

    localparam logic [15:0] c_last_sample = 16'(SAMPLES_PER_FRAME - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
`ifdef SITCP_TX_FRAMER_CHECKSUM_EN
        , ST_TRL = 2'd3
`endif
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_byte_idx;
    logic [15:0] r_sample_idx;
    logic [31:0] r_seq;
    logic [23:0] r_lat;
    logic        r_open_d;
`ifdef SITCP_TX_FRAMER_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    logic        w_emit;
    logic [7:0]  w_byte;
    logic        w_start;
    logic        w_accept;
    logic        w_sample_end;
    logic        w_frame_done;
    logic        w_abort;
    logic        w_open_rise;

    assign w_open_rise = TCP_OPEN_ACK && !r_open_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_emit       = 1'b0;
        w_byte       = 8'h00;
        S_READY      = 1'b0;
        w_start      = 1'b0;
        w_accept     = 1'b0;
        w_sample_end = 1'b0;
        w_frame_done = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ENABLE && TCP_OPEN_ACK && S_VALID) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                if (!TCP_OPEN_ACK) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (!TCP_TX_FULL) begin
                    w_emit = 1'b1;
                    case (r_byte_idx)
                        3'd0:    w_byte = MAGIC[31:24];
                        3'd1:    w_byte = MAGIC[23:16];
                        3'd2:    w_byte = MAGIC[15:8];
                        3'd3:    w_byte = MAGIC[7:0];
                        3'd4:    w_byte = r_seq[31:24];
                        3'd5:    w_byte = r_seq[23:16];
                        3'd6:    w_byte = r_seq[15:8];
                        default: w_byte = r_seq[7:0];
                    endcase
                    if (r_byte_idx == 3'd7) w_state_nxt = ST_PAY;
                end
            end
            ST_PAY: begin
                if (r_byte_idx == 3'd0) S_READY = !TCP_TX_FULL;
                // Connection loss takes priority over everything, including FULL.
                if (!TCP_OPEN_ACK) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_byte_idx == 3'd0) begin
                    if (S_VALID && !TCP_TX_FULL) begin
                        w_accept = 1'b1;
                        w_emit   = 1'b1;
                        w_byte   = S_DATA[31:24];
                    end
                end else if (!TCP_TX_FULL) begin
                    w_emit = 1'b1;
                    case (r_byte_idx)
                        3'd1:    w_byte = r_lat[23:16];
                        3'd2:    w_byte = r_lat[15:8];
                        default: w_byte = r_lat[7:0];
                    endcase
                    if (r_byte_idx == 3'd3) begin
                        w_sample_end = 1'b1;
                        if (r_sample_idx == c_last_sample) begin
`ifdef SITCP_TX_FRAMER_CHECKSUM_EN
                            w_state_nxt  = ST_TRL;
`else
                            w_frame_done = 1'b1;
                            w_state_nxt  = ST_IDLE;
`endif
                        end
                    end
                end
            end
`ifdef SITCP_TX_FRAMER_CHECKSUM_EN
            ST_TRL: begin
                if (!TCP_OPEN_ACK) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (!TCP_TX_FULL) begin
                    w_emit       = 1'b1;
                    w_byte       = r_csum;
                    w_frame_done = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            TCP_TX_WR    <= 1'b0;
            TCP_TX_DATA  <= 8'h00;
            FRAME_CNT    <= 32'd0;
            ABORT_CNT    <= 16'd0;
            r_byte_idx   <= 3'd0;
            r_sample_idx <= 16'd0;
            r_seq        <= 32'd0;
            r_lat        <= 24'd0;
            r_open_d     <= 1'b0;
        end else begin
            r_open_d  <= TCP_OPEN_ACK;
            TCP_TX_WR <= w_emit;
            if (w_emit)   TCP_TX_DATA <= w_byte;
            if (w_accept) r_lat       <= S_DATA[23:0];

            if (w_abort || w_start) begin
                r_byte_idx   <= 3'd0;
                r_sample_idx <= 16'd0;
            end else if (w_emit) begin
                // Header wraps after byte 7, each payload sample after byte 3.
                if ((r_state == ST_PAY && r_byte_idx == 3'd3) || r_byte_idx == 3'd7)
                    r_byte_idx <= 3'd0;
                else
                    r_byte_idx <= r_byte_idx + 3'd1;
                if (w_sample_end)
                    r_sample_idx <= (r_sample_idx == c_last_sample) ? 16'd0 : r_sample_idx + 16'd1;
            end

            if (w_abort && ABORT_CNT != 16'hFFFF) ABORT_CNT <= ABORT_CNT + 16'd1;

            if (w_open_rise) begin
                r_seq     <= 32'd0;
                FRAME_CNT <= 32'd0;
            end else if (w_frame_done) begin
                r_seq     <= r_seq + 32'd1;
                FRAME_CNT <= FRAME_CNT + 32'd1;
            end
        end
    end

`ifdef SITCP_TX_FRAMER_CHECKSUM_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                              r_csum <= 8'h00;
        else if (w_start)                     r_csum <= 8'h00;
        else if (w_emit && r_state != ST_TRL) r_csum <= r_csum ^ w_byte;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sitcp_tcp_tx_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sitcp_tcp_tx_framer
// Brief    : Directed bench for sitcp_tcp_tx_framer with SAMPLES_PER_FRAME=2.
// Revision : 1.0  initial release
// ============================================================================
module tb_sitcp_tcp_tx_framer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ENABLE;
    logic        TCP_OPEN_ACK;
    logic        TCP_TX_FULL;
    logic        TCP_TX_WR;
    logic [7:0]  TCP_TX_DATA;
    logic [31:0] S_DATA;
    logic        S_VALID;
    logic        S_READY;
    logic [31:0] FRAME_CNT;
    logic [15:0] ABORT_CNT;

    always #5 CLK = ~CLK;

    sitcp_tcp_tx_framer #(
        .SAMPLES_PER_FRAME (2),
        .MAGIC             (32'hA5A5_5A5A)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ENABLE       (ENABLE),
        .TCP_OPEN_ACK (TCP_OPEN_ACK),
        .TCP_TX_FULL  (TCP_TX_FULL),
        .TCP_TX_WR    (TCP_TX_WR),
        .TCP_TX_DATA  (TCP_TX_DATA),
        .S_DATA       (S_DATA),
        .S_VALID      (S_VALID),
        .S_READY      (S_READY),
        .FRAME_CNT    (FRAME_CNT),
        .ABORT_CNT    (ABORT_CNT)
    );

    typedef struct {
        logic       en;
        logic       op;
        logic       fl;
        logic       vl;
        logic       rdy;
        logic       wr;
        logic [7:0] dat;
    } vec_t;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] cap[$];
    logic [7:0] exp_q[$];
    logic [31:0] samples [2] = '{32'h0102_0304, 32'h0506_0708};
    logic [7:0]  f1 [16] = '{8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00,
                             8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    logic        sp = 1'b0;
    logic        rdy;
    logic        wr;
    logic [7:0]  dat;
    vec_t        tbl [17];

    always @(negedge CLK) if (TCP_TX_WR) cap.push_back(TCP_TX_DATA);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs; sample S_READY before the edge and the byte port after it.
    task automatic cyc(input logic en, input logic op, input logic fl, input logic vl);
        ENABLE       = en;
        TCP_OPEN_ACK = op;
        TCP_TX_FULL  = fl;
        S_VALID      = vl;
        S_DATA       = samples[sp];
        #1;
        rdy = S_READY;
        if (vl && rdy) sp = ~sp;
        @(posedge CLK);
        #1;
        wr  = TCP_TX_WR;
        dat = TCP_TX_DATA;
    endtask

    task automatic check_stream(input string name);
        check({name, " len"}, 32'(cap.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
            check($sformatf("%s byte%0d", name, i), 32'(cap[i]), 32'(exp_q[i]));
    endtask

    function automatic vec_t mk(input logic vl, input logic rdy_e, input logic wr_e, input logic [7:0] d);
        vec_t v;
        v = '{1'b1, 1'b1, 1'b0, vl, rdy_e, wr_e, d};
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mk(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i < 17; i++)
            tbl[i] = mk(1'b1, (i == 9 || i == 13), 1'b1, f1[i-1]);

        RST = 1'b1; ENABLE = 1'b0; TCP_OPEN_ACK = 1'b0; TCP_TX_FULL = 1'b0;
        S_VALID = 1'b0; S_DATA = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst wr",    32'(TCP_TX_WR),   32'd0);
        check("rst data",  32'(TCP_TX_DATA), 32'd0);
        check("rst frame", FRAME_CNT,        32'd0);
        check("rst abort", 32'(ABORT_CNT),   32'd0);
        check("rst ready", 32'(S_READY),     32'd0);
        RST = 1'b0;

        // Frame 0: uninterrupted, cycle-exact.
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].en, tbl[i].op, tbl[i].fl, tbl[i].vl);
            check($sformatf("t%0d ready", i), 32'(rdy), 32'(tbl[i].rdy));
            check($sformatf("t%0d wr", i),    32'(wr),  32'(tbl[i].wr));
            if (tbl[i].wr) check($sformatf("t%0d data", i), 32'(dat), 32'(tbl[i].dat));
        end
`ifdef SITCP_TX_FRAMER_CHECKSUM_EN
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("trl wr",   32'(wr),  32'd1);
        check("trl data", 32'(dat), 32'h08);
`endif
        check("frame_cnt f0", FRAME_CNT, 32'd1);

        // Frame 1: FULL for 5 cycles at header byte 3, then a 3-cycle S_VALID gap.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cap.delete(); sp = 1'b0;
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b1);
            check($sformatf("full%0d ready", k), 32'(rdy), 32'd0);
            check($sformatf("full%0d wr", k),    32'(wr),  32'd0);
        end
        for (int k = 0; k < 9; k++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            check($sformatf("gap%0d wr", k),    32'(wr),  32'd0);
            check($sformatf("gap%0d ready", k), 32'(rdy), 32'd1);
        end
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
`ifdef SITCP_TX_FRAMER_CHECKSUM_EN
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
`endif
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        exp_q = '{8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h01,
                  8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
`ifdef SITCP_TX_FRAMER_CHECKSUM_EN
        exp_q.push_back(8'h09);
`endif
        check_stream("frame1");
        check("frame_cnt f1", FRAME_CNT, 32'd2);

        // Frame 2: FULL at first payload byte, then connection drops (with FULL) after payload byte 5.
        cap.delete(); sp = 1'b0;
        for (int k = 0; k < 9; k++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        check("pay full ready", 32'(rdy), 32'd0);
        check("pay full wr",    32'(wr),  32'd0);
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        check("abort wr", 32'(wr), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("abort idle wr",    32'(wr),  32'd0);
        check("abort idle ready", 32'(rdy), 32'd0);
        check("abort_cnt",        32'(ABORT_CNT), 32'd1);
        check("frame_cnt abort",  FRAME_CNT, 32'd2);
        exp_q = '{8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h02,
                  8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        check_stream("frame2");

        // Reopen: seq and FRAME_CNT restart; RST lands mid-payload.
        cap.delete(); sp = 1'b0;
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        check("reopen frame_cnt", FRAME_CNT, 32'd0);
        for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
        check("pre-rst wr", 32'(wr), 32'd1);
        #1;
        RST = 1'b1;
        #1;
        check("async rst wr",    32'(TCP_TX_WR),   32'd0);
        check("async rst data",  32'(TCP_TX_DATA), 32'd0);
        check("async rst frame", FRAME_CNT,        32'd0);
        check("async rst abort", 32'(ABORT_CNT),   32'd0);
        exp_q = '{8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        check_stream("reopen");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        cap.delete(); sp = 1'b0;
        for (int k = 0; k < 9; k++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        exp_q = '{8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00};
        check_stream("post-rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
